// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the cpu_sequencer control unit: FSM states, opcode classes and
// the branch-mask field location.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StFetch     = 3'd1,
        StDecode    = 3'd2,
        StExecute   = 3'd3,
        StWriteback = 3'd4,
        StHalt      = 3'd5,
        StFault     = 3'd6
    } seq_state_e;

    typedef enum logic [1:0] {
        ClsNop,
        ClsAlu,
        ClsBr,
        ClsHalt
    } op_class_e;

    localparam logic [3:0]  OP_NOP      = 4'h0;
    localparam logic [3:0]  OP_BR       = 4'hB;
    localparam logic [3:0]  OP_HALT     = 4'hF;
    localparam int unsigned BR_MASK_LSB = 9;
    localparam int unsigned BR_MASK_W   = 3;

    function automatic op_class_e classify(input logic [3:0] op);
        case (op)
            OP_NOP:  return ClsNop;
            OP_BR:   return ClsBr;
            OP_HALT: return ClsHalt;
            default: return ClsAlu;
        endcase
    endfunction

endpackage

// File: rtl/seq_fetch_timer.sv
// Wait-cycle down-counter: reloads to Limit, decrements while waiting and flags the
// cycle in which the last allowed wait is spent. Limit = 0 never expires.
module seq_fetch_timer #(
    parameter int unsigned Limit = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic dec_i,
    output logic expired_o
);

    localparam int unsigned CntW = (Limit > 1) ? $clog2(Limit + 1) : 1;
    localparam logic [CntW-1:0] LoadVal = CntW'(Limit);
    localparam logic [CntW-1:0] LastVal = CntW'(1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LoadVal;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - LastVal;
        end
    end

    // Expires on the wait cycle that would take the count from one to zero.
    assign expired_o = (Limit != 0) && dec_i && (cnt_q == LastVal);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= LoadVal;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback control unit for the 16-bit A/B/ZNC
// datapath, with run/step control, HALT, fetch timeout fault and a retired count.
module cpu_sequencer import cpu_seq_pkg::*; #(
    parameter int unsigned COUNT_W       = 16,
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        opCode,
    input  logic [2:0]         ZNC,
    input  logic               mem_ready,
    input  logic               run,
    input  logic               step,
    output logic               ir_load,
    output logic               pc_en,
    output logic               BR,
    output logic               reg_en,
    output logic               znc_en,
    output logic               halted,
    output logic               fault,
    output logic [2:0]         state,
    output logic [COUNT_W-1:0] instr_count
);

    seq_state_e           state_q, state_d;
    op_class_e            cls_q, cls_d;
    logic [BR_MASK_W-1:0] mask_q, mask_d;
    logic                 taken_q, taken_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 timer_load, timer_dec, timer_expired;
    logic                 unused_opcode;

    assign unused_opcode = ^opCode[BR_MASK_LSB-1:0];

    seq_fetch_timer #(
        .Limit (FETCH_TIMEOUT)
    ) u_fetch_timer (
        .clk_i     (clk),
        .rst_i     (rst),
        .load_i    (timer_load),
        .dec_i     (timer_dec),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        mask_d     = mask_q;
        taken_d    = taken_q;
        count_d    = count_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        ir_load    = 1'b0;
        pc_en      = 1'b0;
        BR         = 1'b0;
        reg_en     = 1'b0;
        znc_en     = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run || step) state_d = StFetch;
            end
            StFetch: begin
                if (mem_ready) begin
                    ir_load    = 1'b1;
                    cls_d      = classify(opCode[15:12]);
                    mask_d     = opCode[BR_MASK_LSB +: BR_MASK_W];
                    timer_load = 1'b1;
                    state_d    = StDecode;
                end else begin
                    timer_dec = 1'b1;
                    if (timer_expired) state_d = StFault;
                end
            end
            StDecode: begin
                state_d = (cls_q == ClsHalt) ? StHalt : StExecute;
            end
            StExecute: begin
                // Flags are sampled here so the ALU result of the previous writeback is visible.
                taken_d = (mask_q == '0) || ((mask_q & ZNC) != '0);
                state_d = StWriteback;
            end
            StWriteback: begin
                pc_en = 1'b1;
                case (cls_q)
                    ClsAlu: begin
                        reg_en = 1'b1;
                        znc_en = 1'b1;
                    end
                    ClsBr:   BR = taken_q;
                    default: ;
                endcase
                count_d = count_q + COUNT_W'(1);
                state_d = run ? StFetch : StIdle;
            end
            StHalt:  halted = 1'b1;
            StFault: fault  = 1'b1;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cls_q   <= ClsNop;
            mask_q  <= '0;
            taken_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            mask_q  <= mask_d;
            taken_q <= taken_d;
            count_q <= count_d;
        end
    end

    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: drivers queue the expected writeback of each
// instruction, a negedge monitor checks every pc_en pulse against the queue.
module tb_cpu_sequencer;

    localparam int unsigned CW = 4;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   opCode = '0;
    logic [2:0]    ZNC = '0;
    logic          mem_ready = 1'b0;
    logic          run = 1'b0;
    logic          step = 1'b0;
    logic          ir_load, pc_en, BR, reg_en, znc_en, halted, fault;
    logic [2:0]    state;
    logic [CW-1:0] instr_count;

    int checks = 0;
    int failures = 0;
    int model_count = 0;
    int zrun = 0;

    typedef struct packed {
        logic          reg_en;
        logic          znc_en;
        logic          br;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    cpu_sequencer #(
        .COUNT_W       (CW),
        .FETCH_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .opCode      (opCode),
        .ZNC         (ZNC),
        .mem_ready   (mem_ready),
        .run         (run),
        .step        (step),
        .ir_load     (ir_load),
        .pc_en       (pc_en),
        .BR          (BR),
        .reg_en      (reg_en),
        .znc_en      (znc_en),
        .halted      (halted),
        .fault       (fault),
        .state       (state),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected writeback of one retired instruction, straight from the opcode rules.
    function automatic exp_t model(input logic [15:0] op, input logic [2:0] znc, input int cnt);
        exp_t       e;
        logic [3:0] top;
        logic [2:0] mask;
        top      = op[15:12];
        mask     = op[11:9];
        e.reg_en = (top != 4'h0) && (top != 4'hB);
        e.znc_en = e.reg_en;
        e.br     = (top == 4'hB) && ((mask == 3'b000) || ((mask & znc) != 3'b000));
        e.cnt    = CW'(cnt);
        return e;
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] op;
        op = 16'($urandom);
        case ($urandom_range(0, 3))
            0:       op[15:12] = 4'h0;
            1:       op[15:12] = 4'hB;
            default: if (op[15:12] == 4'hF) op[15:12] = 4'h1;
        endcase
        return op;
    endfunction

    always @(negedge clk) begin
        if (pc_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pc_en", 32'(pc_en), 32'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_reg_en", 32'(reg_en), 32'(mon_e.reg_en));
                check("wb_znc_en", 32'(znc_en), 32'(mon_e.znc_en));
                check("wb_br", 32'(BR), 32'(mon_e.br));
                check("wb_count", 32'(instr_count), 32'(mon_e.cnt));
            end
        end else begin
            check("stray_enables", 32'({reg_en, znc_en, BR}), 32'(0));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        step = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_count = 0;
        zrun = 0;
        exp_q.delete();
    endtask

    // Issues one instruction while running and returns on its writeback negedge.
    task automatic run_instr(input logic [15:0] op, input logic [2:0] znc, input bit stalls,
                             input bit timing);
        int n;
        bit done;
        opCode = op;
        ZNC = znc;
        exp_q.push_back(model(op, znc, model_count));
        model_count++;
        n = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (stalls) begin
                mem_ready = (zrun >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
                zrun = mem_ready ? 0 : zrun + 1;
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            if (timing) check("ir_load_timing", 32'(ir_load), 32'(n == 1));
            if (pc_en) done = 1'b1;
        end
        if (!done) check("wb_timeout", 32'(done), 32'(1));
        else if (timing) check("latency", 32'(n), 32'(4));
    endtask

    // Single-steps one instruction from IDLE, peppering step pulses through the instruction.
    task automatic step_instr(input logic [15:0] op, input logic [2:0] znc);
        int n;
        bit done;
        opCode = op;
        ZNC = znc;
        exp_q.push_back(model(op, znc, model_count));
        model_count++;
        n = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            mem_ready = 1'b1;
            if (pc_en) begin
                step = 1'b0;
                done = 1'b1;
            end else begin
                step = (n == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end
        if (!done) check("step_timeout", 32'(done), 32'(1));
        step = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("step_idle_state", 32'(state), 32'(0));
        check("step_count", 32'(instr_count), 32'(CW'(model_count)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        #1;
        check("reset_state", 32'(state), 32'(0));
        check("reset_count", 32'(instr_count), 32'(0));
        check("reset_flags", 32'({halted, fault, pc_en, ir_load}), 32'(0));

        // Directed: ALU, branches, NOP with no memory stalls.
        run = 1'b1;
        run_instr(16'h1234, 3'b000, 1'b0, 1'b1);
        run_instr(16'h1234, 3'b111, 1'b0, 1'b1);
        run_instr(16'hB200, 3'b100, 1'b0, 1'b1);
        run_instr(16'hB200, 3'b011, 1'b0, 1'b1);
        run_instr(16'hB000, 3'b000, 1'b0, 1'b1);
        run_instr(16'hB000, 3'($urandom), 1'b0, 1'b1);
        run_instr(16'h0ABC, 3'b101, 1'b0, 1'b1);

        // Randomised instruction stream with memory stalls below the timeout.
        repeat (60) run_instr(rand_op(), 3'($urandom), 1'b1, 1'b0);

        // Single step mode.
        run = 1'b0;
        repeat (4) step_instr(rand_op(), 3'($urandom));

        // Fetch timeout: four stalled FETCH cycles, then FAULT.
        mem_ready = 1'b0;
        run = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            #1;
            check("pre_fault_state", 32'(state), 32'(1));
            check("pre_fault_flag", 32'(fault), 32'(0));
        end
        @(negedge clk);
        #1;
        check("fault_flag", 32'(fault), 32'(1));
        check("fault_state", 32'(state), 32'(6));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            step = 1'($urandom_range(0, 1));
            #1;
            check("fault_sticky", 32'(fault), 32'(1));
        end
        do_reset();
        #1;
        check("fault_reset_state", 32'(state), 32'(0));
        check("fault_reset_flag", 32'(fault), 32'(0));
        check("fault_reset_count", 32'(instr_count), 32'(0));

        // HALT after a few retired instructions.
        run = 1'b1;
        repeat (3) run_instr(rand_op(), 3'($urandom), 1'b0, 1'b1);
        opCode = 16'hF000;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            #1;
            check("pre_halt_flag", 32'(halted), 32'(0));
        end
        @(negedge clk);
        #1;
        check("halt_flag", 32'(halted), 32'(1));
        check("halt_state", 32'(state), 32'(5));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            run = 1'($urandom_range(0, 1));
            step = 1'($urandom_range(0, 1));
            #1;
            check("halt_sticky", 32'(halted), 32'(1));
            check("halt_count", 32'(instr_count), 32'(CW'(model_count)));
        end
        do_reset();

        // Reset asserted while an instruction is in WRITEBACK.
        run = 1'b1;
        repeat (2) run_instr(rand_op(), 3'($urandom), 1'b0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("wb_reset_pc_en", 32'({pc_en, reg_en, znc_en, BR}), 32'(0));
        check("wb_reset_state", 32'(state), 32'(0));
        check("wb_reset_count", 32'(instr_count), 32'(0));
        rst = 1'b0;
        run = 1'b0;
        model_count = 0;

        // Counter wrap: sixteen retirements with a 4-bit counter.
        do_reset();
        run = 1'b1;
        repeat (16) run_instr(rand_op(), 3'($urandom), 1'b0, 1'b1);
        run = 1'b0;
        @(negedge clk);
        #1;
        check("wrap_state", 32'(state), 32'(0));
        check("wrap_count", 32'(instr_count), 32'(0));

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
